// File: rtl/native_port_responder.sv
// native_port_responder: controller-side endpoint of the DMA native port.
// Accepts one command at a time from the DMA initiator. Write data is collected
// before the command goes out, and each command is issued as a single request
// to the memory-controller backend. Read returns are queued in order in a small
// FIFO. Before a read is accepted, a credit check reserves space for its data,
// so the backend return path never needs backpressure.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. Once the request to the backend is raised, bk_req_valid_o and its
// payload stay stable until bk_req_ready_i. The backend read return has no ready
// signal and is always taken.
module native_port_responder #(
    parameter int DDR_DATA_W = 128,
    parameter int DDR_MASK_W = DDR_DATA_W / 8,
    parameter int DDR_ADDR_W = 32,
    parameter int RD_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ncmd_valid_i,
    output logic                  ncmd_ready_o,
    input  logic [DDR_ADDR_W-1:0] ncmd_payload_addr_i,
    input  logic                  ncmd_payload_we_i,
    input  logic                  ncmd_payload_mw_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DDR_DATA_W-1:0] wdata_payload_data_i,
    input  logic [DDR_MASK_W-1:0] wdata_payload_we_i,
    output logic                  rdata_valid_o,
    input  logic                  rdata_ready_i,
    output logic [DDR_DATA_W-1:0] rdata_payload_data_o,
    output logic                  bk_req_valid_o,
    input  logic                  bk_req_ready_i,
    output logic [DDR_ADDR_W-1:0] bk_req_addr_o,
    output logic                  bk_req_we_o,
    output logic [DDR_DATA_W-1:0] bk_req_wdata_o,
    output logic [DDR_MASK_W-1:0] bk_req_wmask_o,
    input  logic                  bk_rdata_valid_i,
    input  logic [DDR_DATA_W-1:0] bk_rdata_i,
    output logic                  err_o,
    output logic [1:0]            dbg_state_o
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(RD_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                state;
    logic                  live;
    logic                  cmd_mw;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DDR_DATA_W-1:0] mem [RD_DEPTH];
    logic [CW:0]           credits_used;
    logic                  issue_rd;
    logic                  ret_ok;
    logic                  pop;

    // Space is reserved for reads that are in flight and for data already queued.
    assign credits_used  = {1'b0, inflight} + {1'b0, fifo_count};
    // live stays low for the first clock after reset, so ready cannot rise during reset.
    assign ncmd_ready_o  = live && (state == IDLE) && (credits_used < DEPTH_C);
    assign issue_rd      = bk_req_valid_o && bk_req_ready_i && !bk_req_we_o;
    assign ret_ok        = bk_rdata_valid_i && (inflight != '0);
    assign rdata_valid_o = (fifo_count != '0);
    assign pop           = rdata_valid_o && rdata_ready_i;
    assign rdata_payload_data_o = mem[rd_ptr];
    assign dbg_state_o   = state;

    // Command FSM: latch the command, gather write data, and hold the backend request until it is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            live           <= 1'b0;
            cmd_mw         <= 1'b0;
            wdata_ready_o  <= 1'b0;
            bk_req_valid_o <= 1'b0;
            bk_req_addr_o  <= '0;
            bk_req_we_o    <= 1'b0;
            bk_req_wdata_o <= '0;
            bk_req_wmask_o <= '0;
        end else begin
            live <= 1'b1;
            case (state)
                IDLE: begin
                    if (ncmd_valid_i && ncmd_ready_o) begin
                        bk_req_addr_o <= ncmd_payload_addr_i;
                        bk_req_we_o   <= ncmd_payload_we_i;
                        cmd_mw        <= ncmd_payload_mw_i;
                        if (ncmd_payload_we_i) begin
                            wdata_ready_o <= 1'b1;
                            state         <= WDATA;
                        end else begin
                            bk_req_valid_o <= 1'b1;
                            state          <= ISSUE;
                        end
                    end
                end
                WDATA: begin
                    if (wdata_valid_i) begin
                        bk_req_wdata_o <= wdata_payload_data_i;
                        bk_req_wmask_o <= cmd_mw ? wdata_payload_we_i : '1;
                        wdata_ready_o  <= 1'b0;
                        bk_req_valid_o <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bk_req_ready_i) begin
                        bk_req_valid_o <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit and FIFO bookkeeping. A read return that arrives with nothing in flight is dropped and sets the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_o      <= 1'b0;
            for (int i = 0; i < RD_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (issue_rd && !ret_ok)      inflight <= inflight + 1'b1;
            else if (!issue_rd && ret_ok) inflight <= inflight - 1'b1;

            if (ret_ok && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!ret_ok && pop) fifo_count <= fifo_count - 1'b1;

            if (ret_ok) begin
                mem[wr_ptr] <= bk_rdata_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (bk_rdata_valid_i && (inflight == '0)) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_native_port_responder.sv
// Bench for native_port_responder. A transaction-level model tracks the open
// command, the reads still owed by the backend and the expected read-data
// queue. A compare process checks every DUT output against that model at each
// falling edge. Directed scenarios pin literal values, and a randomized phase
// drives the ports after that.
module tb_native_port_responder;

    localparam int DW    = 128;
    localparam int MW    = 16;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          ncmd_valid_i, ncmd_ready_o;
    logic [AW-1:0] ncmd_payload_addr_i;
    logic          ncmd_payload_we_i, ncmd_payload_mw_i;
    logic          wdata_valid_i, wdata_ready_o;
    logic [DW-1:0] wdata_payload_data_i;
    logic [MW-1:0] wdata_payload_we_i;
    logic          rdata_valid_o, rdata_ready_i;
    logic [DW-1:0] rdata_payload_data_o;
    logic          bk_req_valid_o, bk_req_ready_i;
    logic [AW-1:0] bk_req_addr_o;
    logic          bk_req_we_o;
    logic [DW-1:0] bk_req_wdata_o;
    logic [MW-1:0] bk_req_wmask_o;
    logic          bk_rdata_valid_i;
    logic [DW-1:0] bk_rdata_i;
    logic          err_o;
    logic [1:0]    dbg_state_o;

    native_port_responder #(
        .DDR_DATA_W(DW), .DDR_MASK_W(MW), .DDR_ADDR_W(AW), .RD_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ncmd_valid_i(ncmd_valid_i), .ncmd_ready_o(ncmd_ready_o),
        .ncmd_payload_addr_i(ncmd_payload_addr_i),
        .ncmd_payload_we_i(ncmd_payload_we_i), .ncmd_payload_mw_i(ncmd_payload_mw_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_payload_data_i(wdata_payload_data_i), .wdata_payload_we_i(wdata_payload_we_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
        .rdata_payload_data_o(rdata_payload_data_o),
        .bk_req_valid_o(bk_req_valid_o), .bk_req_ready_i(bk_req_ready_i),
        .bk_req_addr_o(bk_req_addr_o), .bk_req_we_o(bk_req_we_o),
        .bk_req_wdata_o(bk_req_wdata_o), .bk_req_wmask_o(bk_req_wmask_o),
        .bk_rdata_valid_i(bk_rdata_valid_i), .bk_rdata_i(bk_rdata_i),
        .err_o(err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- scoreboard / counts ----------------
    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- behavioural model ----------------
    bit            m_live;      // one clock has passed since reset release
    bit            have_cmd;    // a command is accepted but not yet handed to the backend
    bit            have_data;   // write data for that command has been collected
    logic [AW-1:0] m_addr;
    logic          m_we, m_mw;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    int            outstanding; // reads issued and not yet returned
    bit            m_err;
    logic [DW-1:0] exp_q[$];    // read data owed to the DMA, in order

    function automatic bit exp_ncmd_ready();
        return m_live && !have_cmd && (outstanding + exp_q.size() < DEPTH);
    endfunction
    function automatic bit exp_wready();
        return have_cmd && m_we && !have_data;
    endfunction
    function automatic bit exp_req_valid();
        return have_cmd && (!m_we || have_data);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit cmd_hs, wd_hs, req_hs, ret, pop;
        int out_pre;
        if (!rst_n) begin
            m_live = 0; have_cmd = 0; have_data = 0;
            outstanding = 0; m_err = 0;
            exp_q.delete();
        end else begin
            cmd_hs  = ncmd_valid_i && exp_ncmd_ready();
            wd_hs   = wdata_valid_i && exp_wready();
            req_hs  = exp_req_valid() && bk_req_ready_i;
            ret     = bk_rdata_valid_i;
            pop     = (exp_q.size() != 0) && rdata_ready_i;
            out_pre = outstanding;
            if (pop) void'(exp_q.pop_front());
            if (ret) begin
                if (out_pre == 0) m_err = 1;
                else begin
                    exp_q.push_back(bk_rdata_i);
                    outstanding--;
                end
            end
            if (req_hs) begin
                if (!m_we) outstanding++;
                have_cmd = 0; have_data = 0;
            end
            if (wd_hs) begin
                have_data = 1;
                m_wdata   = wdata_payload_data_i;
                m_wmask   = m_mw ? wdata_payload_we_i : {MW{1'b1}};
            end
            if (cmd_hs) begin
                have_cmd = 1;
                m_addr   = ncmd_payload_addr_i;
                m_we     = ncmd_payload_we_i;
                m_mw     = ncmd_payload_mw_i;
            end
            m_live = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ncmd_ready", ncmd_ready_o, 0);
            chk("rst_wdata_ready", wdata_ready_o, 0);
            chk("rst_req_valid", bk_req_valid_o, 0);
            chk("rst_rdata_valid", rdata_valid_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_req_addr", bk_req_addr_o, 0);
            chk("rst_req_wdata", bk_req_wdata_o, 0);
            chk("rst_req_wmask", bk_req_wmask_o, 0);
            chk("rst_req_we", bk_req_we_o, 0);
            chk("rst_rdata", rdata_payload_data_o, 0);
        end else begin
            chk("ncmd_ready", ncmd_ready_o, exp_ncmd_ready());
            chk("wdata_ready", wdata_ready_o, exp_wready());
            chk("bk_req_valid", bk_req_valid_o, exp_req_valid());
            chk("rdata_valid", rdata_valid_o, exp_q.size() != 0);
            chk("err", err_o, m_err);
            if (exp_req_valid()) begin
                chk("bk_req_addr", bk_req_addr_o, m_addr);
                chk("bk_req_we", bk_req_we_o, m_we);
                if (m_we) begin
                    chk("bk_req_wdata", bk_req_wdata_o, m_wdata);
                    chk("bk_req_wmask", bk_req_wmask_o, m_wmask);
                end
            end
            if (exp_q.size() != 0) chk("rdata", rdata_payload_data_o, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ncmd_valid_i = 0; ncmd_payload_addr_i = '0; ncmd_payload_we_i = 0; ncmd_payload_mw_i = 0;
        wdata_valid_i = 0; wdata_payload_data_i = '0; wdata_payload_we_i = '0;
        rdata_ready_i = 0; bk_req_ready_i = 0; bk_rdata_valid_i = 0; bk_rdata_i = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d1, d2, d3;
        int guard;
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();

        // Single read to 0x100, returned as all 0xA5 bytes
        ncmd_valid_i = 1; ncmd_payload_addr_i = 32'h100; ncmd_payload_we_i = 0;
        bk_req_ready_i = 1;
        @(negedge clk); chk("t1_cmd_ready", ncmd_ready_o, 1);
        tick(); ncmd_valid_i = 0;
        @(negedge clk); chk("t1_req_valid", bk_req_valid_o, 1); chk("t1_req_addr", bk_req_addr_o, 32'h100);
        tick();
        @(negedge clk); chk("t1_ready_again", ncmd_ready_o, 1); chk("t1_req_done", bk_req_valid_o, 0);
        tick(); bk_rdata_valid_i = 1; bk_rdata_i = {16{8'hA5}};
        tick(); bk_rdata_valid_i = 0;
        @(negedge clk);
        chk("t1_rvalid", rdata_valid_o, 1);
        chk("t1_rdata", rdata_payload_data_o, {16{8'hA5}});
        chk("t1_err", err_o, 0);
        rdata_ready_i = 1; tick(); rdata_ready_i = 0;
        @(negedge clk); chk("t1_drained", rdata_valid_o, 0);

        // Masked write, then full write with the same byte enables
        tick(); bk_req_ready_i = 0;
        ncmd_valid_i = 1; ncmd_payload_we_i = 1; ncmd_payload_mw_i = 1; ncmd_payload_addr_i = 32'h200;
        tick(); ncmd_valid_i = 0;
        d1 = rand128(); wdata_valid_i = 1; wdata_payload_data_i = d1; wdata_payload_we_i = 16'h000F;
        @(negedge clk); chk("t2_wready", wdata_ready_o, 1);
        tick(); wdata_valid_i = 0;
        @(negedge clk);
        chk("t2_mw_mask", bk_req_wmask_o, 16'h000F);
        chk("t2_mw_data", bk_req_wdata_o, d1);
        chk("t2_mw_we", bk_req_we_o, 1);
        bk_req_ready_i = 1; tick(); bk_req_ready_i = 0;
        ncmd_valid_i = 1; ncmd_payload_we_i = 1; ncmd_payload_mw_i = 0; ncmd_payload_addr_i = 32'h204;
        tick(); ncmd_valid_i = 0;
        d2 = rand128(); wdata_valid_i = 1; wdata_payload_data_i = d2; wdata_payload_we_i = 16'h000F;
        tick(); wdata_valid_i = 0;
        @(negedge clk);
        chk("t2_full_mask", bk_req_wmask_o, 16'hFFFF);
        chk("t2_full_data", bk_req_wdata_o, d2);
        bk_req_ready_i = 1; tick(); bk_req_ready_i = 0;

        // Credit limit: five reads with the DMA not accepting read data
        bk_req_ready_i = 1; rdata_ready_i = 0;
        ncmd_valid_i = 1; ncmd_payload_we_i = 0; ncmd_payload_mw_i = 0; ncmd_payload_addr_i = 32'h300;
        repeat (8) tick();
        @(negedge clk); chk("t3_full", ncmd_ready_o, 0);
        for (int i = 0; i < 4; i++) begin
            bk_rdata_valid_i = 1; bk_rdata_i = rand128();
            tick();
        end
        bk_rdata_valid_i = 0;
        @(negedge clk); chk("t3_still_full", ncmd_ready_o, 0); chk("t3_rvalid", rdata_valid_o, 1);
        rdata_ready_i = 1; tick(); rdata_ready_i = 0;
        @(negedge clk); chk("t3_credit_back", ncmd_ready_o, 1);
        tick(); ncmd_valid_i = 0;
        tick(); bk_rdata_valid_i = 1; bk_rdata_i = rand128();
        tick(); bk_rdata_valid_i = 0; rdata_ready_i = 1;
        repeat (6) tick();
        rdata_ready_i = 0;

        // Backend stall: the request must hold for five cycles with no new command taken
        bk_req_ready_i = 0;
        ncmd_valid_i = 1; ncmd_payload_we_i = 1; ncmd_payload_mw_i = 1; ncmd_payload_addr_i = 32'h500;
        tick();
        ncmd_payload_we_i = 0; ncmd_payload_mw_i = 0; ncmd_payload_addr_i = 32'h600;
        d3 = rand128(); wdata_valid_i = 1; wdata_payload_data_i = d3; wdata_payload_we_i = 16'h5A5A;
        tick(); wdata_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_valid", bk_req_valid_o, 1);
            chk("t4_addr", bk_req_addr_o, 32'h500);
            chk("t4_we", bk_req_we_o, 1);
            chk("t4_wdata", bk_req_wdata_o, d3);
            chk("t4_wmask", bk_req_wmask_o, 16'h5A5A);
            chk("t4_no_accept", ncmd_ready_o, 0);
            tick();
        end
        bk_req_ready_i = 1;
        tick();
        tick(); ncmd_valid_i = 0;
        tick(); bk_rdata_valid_i = 1; bk_rdata_i = rand128();
        tick(); bk_rdata_valid_i = 0; rdata_ready_i = 1;
        repeat (3) tick();
        rdata_ready_i = 0;

        // Spurious return with nothing in flight: dropped, sticky error
        bk_rdata_valid_i = 1; bk_rdata_i = rand128();
        tick(); bk_rdata_valid_i = 0;
        @(negedge clk); chk("t5_err_set", err_o, 1); chk("t5_no_push", rdata_valid_o, 0);
        repeat (3) tick();
        @(negedge clk); chk("t5_err_sticky", err_o, 1);
        tick(); rst_n = 0;
        @(negedge clk); chk("t5_err_cleared", err_o, 0);
        tick(); rst_n = 1;
        tick();

        // Reset while waiting for write data with two reads in flight
        bk_req_ready_i = 1; rdata_ready_i = 0;
        ncmd_valid_i = 1; ncmd_payload_we_i = 0; ncmd_payload_addr_i = 32'h700;
        repeat (4) tick();
        ncmd_payload_we_i = 1; ncmd_payload_addr_i = 32'h800;
        tick(); ncmd_valid_i = 0;
        @(negedge clk); chk("t6_in_wdata", wdata_ready_o, 1);
        tick(); rst_n = 0;
        @(negedge clk);
        chk("t6_rst_ncmd_ready", ncmd_ready_o, 0);
        chk("t6_rst_wready", wdata_ready_o, 0);
        chk("t6_rst_req_valid", bk_req_valid_o, 0);
        chk("t6_rst_rvalid", rdata_valid_o, 0);
        tick(); rst_n = 1; idle_inputs();
        tick();
        @(negedge clk); chk("t6_ready_after", ncmd_ready_o, 1); chk("t6_empty_after", rdata_valid_o, 0);

        // Randomized traffic
        tick();
        for (int c = 0; c < 3000; c++) begin
            ncmd_valid_i         = 1'($urandom_range(0, 1));
            ncmd_payload_addr_i  = $urandom;
            ncmd_payload_we_i    = 1'($urandom_range(0, 1));
            ncmd_payload_mw_i    = 1'($urandom_range(0, 1));
            wdata_valid_i        = 1'($urandom_range(0, 1));
            wdata_payload_data_i = rand128();
            wdata_payload_we_i   = 16'($urandom);
            bk_req_ready_i       = ($urandom_range(0, 3) != 0);
            bk_rdata_valid_i     = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            bk_rdata_i           = rand128();
            rdata_ready_i        = 1'($urandom_range(0, 1));
            tick();
        end

        // Drain everything still open
        ncmd_valid_i = 0; wdata_valid_i = 1; bk_req_ready_i = 1; rdata_ready_i = 1;
        guard = 0;
        while ((have_cmd || outstanding != 0 || exp_q.size() != 0) && guard < 200) begin
            bk_rdata_valid_i = (outstanding > 0);
            bk_rdata_i       = rand128();
            tick();
            guard++;
        end
        idle_inputs();
        if (guard >= 200) begin
            n_total++;
            $display("FAIL drain_timeout: traffic still open after %0d cycles, required none", guard);
        end
        tick();
        @(negedge clk); chk("end_ready", ncmd_ready_o, 1); chk("end_empty", rdata_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/native_port_responder.md
# native_port_responder

Controller-side endpoint of the DMA native port: accepts commands and write data from the DMA initiator, issues one-at-a-time requests to the memory-controller backend, and returns read data in order through a small read-data FIFO. It sits between the DMA engine's native interface and the LPDDR4 controller's request arbiter. A credit counter reserves read-buffer space before any read is issued, so the backend never needs backpressure.

## Interface

Parameters:
- DDR_DATA_W, 128, native data width (bits)
- DDR_MASK_W, DDR_DATA_W/8, byte-enable width
- DDR_ADDR_W, 32, native address width
- RD_DEPTH, 4, read-data FIFO depth; must be a power of 2 and ≥2

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- ncmd_valid_i  in  1  command valid from DMA
- ncmd_ready_o  out  1  command accepted
- ncmd_payload_addr_i  in  DDR_ADDR_W  command address
- ncmd_payload_we_i  in  1  1=write, 0=read
- ncmd_payload_mw_i  in  1  1=masked write (use byte enables), 0=full write
- wdata_valid_i  in  1  write data valid
- wdata_ready_o  out  1  write data accepted
- wdata_payload_data_i  in  DDR_DATA_W  write data
- wdata_payload_we_i  in  DDR_MASK_W  byte enables, 1=byte written
- rdata_valid_o  out  1  read data valid to DMA
- rdata_ready_i  in  1  DMA accepts read data
- rdata_payload_data_o  out  DDR_DATA_W  read data
- bk_req_valid_o  out  1  backend request valid
- bk_req_ready_i  in  1  backend accepts request
- bk_req_addr_o  out  DDR_ADDR_W  request address
- bk_req_we_o  out  1  request is write
- bk_req_wdata_o  out  DDR_DATA_W  write data
- bk_req_wmask_o  out  DDR_MASK_W  byte enables
- bk_rdata_valid_i  in  1  backend read return (no backpressure)
- bk_rdata_i  in  DDR_DATA_W  backend read data
- err_o  out  1  sticky protocol error

## Operation

- FSM states: IDLE, WDATA, ISSUE.
- IDLE: ncmd_ready_o = (inflight + fifo_count < RD_DEPTH); the check applies regardless of we. On handshake, latch addr/we/mw. Write → WDATA; read → ISSUE.
- WDATA: wdata_ready_o=1. On handshake, latch data; mask = wdata_payload_we_i if mw=1, else all ones → ISSUE. wdata_ready_o=0 in every other state; early write data stays stalled at the initiator.
- ISSUE: bk_req_valid_o=1, payload held stable. On bk_req_ready_i → IDLE. A read handshake increments inflight.
- Read return:
  - bk_rdata_valid_i pushes bk_rdata_i into the FIFO and decrements inflight.
  - If inflight==0, the return is dropped and err_o is set; err_o clears only on reset.
- FIFO output: rdata_valid_o = !empty; rdata_payload_data_o = head entry, registered (not fall-through). Pop on rdata_valid_o & rdata_ready_i.
- Push and pop in the same cycle are both performed; count is unchanged.
- Overflow cannot occur because credits reserve space. Pointers wrap modulo RD_DEPTH.
- Counter widths: inflight and fifo_count are $clog2(RD_DEPTH)+1 bits. Sum stays ≤ RD_DEPTH.
- Reset (any time, including mid-transaction): state IDLE; FIFO emptied; inflight=0; latched command discarded. Every output is 0 except wdata_ready_o=0 and ncmd_ready_o=0 while rst_n is low. ncmd_ready_o reflects credits from the first cycle after deassertion.

## Timing

- Read: ncmd handshake at cycle 0 → bk_req_valid_o high at cycle 1. If bk_req_ready_i=1 at cycle 1, ncmd_ready_o is high again at cycle 2.
- Write: ncmd at cycle 0; wdata_ready_o high at cycle 1. Wdata handshake at cycle k → bk_req_valid_o at k+1.
- bk_rdata_valid_i at cycle N → rdata_valid_o at N+1.
- Maximum throughput: one read per 2 cycles, one write per 3 cycles.
- bk_req_valid_o, once high, stays high with a stable payload until bk_req_ready_i.

## Test plan

- Single read to 0x100, backend ready immediately, return 0xA5..A5 two cycles later → bk_req at cycle 1; rdata_valid_o with 0xA5..A5 one cycle after return; err_o=0.
- Masked write (mw=1, we=0x000F), then full write (mw=0, we=0x000F) → first bk_req_wmask_o=0x000F, second all ones; data matches.
- RD_DEPTH=4, rdata_ready_i=0, issue 5 reads, backend returns all → ncmd_ready_o low after 4th accept; rises only after the first rdata pop.
- Backend holds bk_req_ready_i=0 for 5 cycles → addr/we/wdata/wmask stable on bk_req throughout; no second command accepted.
- Spurious bk_rdata_valid_i with inflight=0 → no FIFO push, err_o=1 and stays 1; rst_n low clears it.
- Assert rst_n low while in WDATA with 2 reads in flight → all outputs 0; after release, ncmd_ready_o=1, rdata_valid_o=0.
